// File: rtl/ultrasonic_transmitter.sv
// -----------------------------------------------------------------------------
// ultrasonic_transmitter
//
// Generates a push-pull ultrasonic excitation burst, then holds off for a
// programmable blanking interval before enabling the receive chain.
//
// A burst is NUM_PULSES carrier periods. Each period is DRV_P, DEAD_P, DRV_N,
// DEAD_N. Each drive phase lasts HALF_PERIOD-DEAD_CYCLES cycles and each dead
// phase lasts DEAD_CYCLES cycles. After the burst, HOLD lasts HOLDOFF cycles.
// On completion, RX_EN rises and DONE pulses for one cycle.
//
// Parameters:
//   HALF_PERIOD  SYS_CLK cycles per half carrier period (2..65535)
//   DEAD_CYCLES  both-low time at the end of each half period
//                (1 <= DEAD_CYCLES < HALF_PERIOD)
//
// Ports:
//   SYS_CLK     in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   ON          in   block enable; low aborts everything at the next edge
//   FIRE        in   burst request, sampled every cycle
//   NUM_PULSES  in   [7:0]  carrier periods per burst, latched on accept
//   HOLDOFF     in   [15:0] blanking cycles after the burst, latched on accept
//   TX_P        out  positive drive leg
//   TX_N        out  negative drive leg
//   BUSY        out  burst or hold-off in progress
//   RX_EN       out  receiver enable level
//   DONE        out  one-cycle pulse when hold-off completes
// -----------------------------------------------------------------------------
module ultrasonic_transmitter #(
    parameter int unsigned HALF_PERIOD = 625,
    parameter int unsigned DEAD_CYCLES = 10
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        ON,
    input  logic        FIRE,
    input  logic [7:0]  NUM_PULSES,
    input  logic [15:0] HOLDOFF,
    output logic        TX_P,
    output logic        TX_N,
    output logic        BUSY,
    output logic        RX_EN,
    output logic        DONE
);

    localparam logic [15:0] DRIVE_LEN = 16'(HALF_PERIOD - DEAD_CYCLES);
    localparam logic [15:0] DEAD_LEN  = 16'(DEAD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        DRV_P,
        DEAD_P,
        DRV_N,
        DEAD_N,
        HOLD
    } state_t;

    state_t      state, state_nx;
    // The accepting edge only latches the request and clears RX_EN.
    // The burst starts one edge later, so this flag bridges that cycle.
    logic        launch, launch_nx;
    logic [15:0] half_cnt, half_nx;
    logic [7:0]  pulse_cnt, pulse_nx;
    logic [15:0] hold_cnt, hold_nx;
    logic        rx_en_nx, done_nx;

    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // This way, a path that forgets an assignment holds the value
        // instead of inferring a latch.
        state_nx  = state;
        launch_nx = 1'b0;
        half_nx   = half_cnt;
        pulse_nx  = pulse_cnt;
        hold_nx   = hold_cnt;
        rx_en_nx  = RX_EN;
        done_nx   = 1'b0;

        if (!ON) begin
            state_nx = IDLE;
            half_nx  = '0;
            pulse_nx = '0;
            hold_nx  = '0;
            rx_en_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state_nx = DRV_P;
                        half_nx  = DRIVE_LEN;
                    end else if (FIRE && NUM_PULSES != 8'd0) begin
                        launch_nx = 1'b1;
                        pulse_nx  = NUM_PULSES;
                        hold_nx   = HOLDOFF;
                        rx_en_nx  = 1'b0;
                    end
                end
                DRV_P, DRV_N: begin
                    if (half_cnt == 16'd1) begin
                        state_nx = (state == DRV_P) ? DEAD_P : DEAD_N;
                        half_nx  = DEAD_LEN;
                    end else begin
                        half_nx = half_cnt - 16'd1;
                    end
                end
                DEAD_P: begin
                    if (half_cnt == 16'd1) begin
                        state_nx = DRV_N;
                        half_nx  = DRIVE_LEN;
                    end else begin
                        half_nx = half_cnt - 16'd1;
                    end
                end
                DEAD_N: begin
                    if (half_cnt != 16'd1) begin
                        half_nx = half_cnt - 16'd1;
                    end else if (pulse_cnt != 8'd1) begin
                        pulse_nx = pulse_cnt - 8'd1;
                        state_nx = DRV_P;
                        half_nx  = DRIVE_LEN;
                    end else begin
                        pulse_nx = '0;
                        half_nx  = '0;
                        if (hold_cnt == 16'd0) begin
                            // A zero hold-off completes directly from the last dead phase.
                            state_nx = IDLE;
                            rx_en_nx = 1'b1;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 16'd1) begin
                        hold_nx  = '0;
                        state_nx = IDLE;
                        rx_en_nx = 1'b1;
                        done_nx  = 1'b1;
                    end else begin
                        hold_nx = hold_cnt - 16'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // The outputs are registered decodes of the next state. As a result,
    // they change on the same edge as the state. TX_P and TX_N come from
    // mutually exclusive states, so they can never be high together.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            launch    <= 1'b0;
            half_cnt  <= '0;
            pulse_cnt <= '0;
            hold_cnt  <= '0;
            TX_P      <= 1'b0;
            TX_N      <= 1'b0;
            BUSY      <= 1'b0;
            RX_EN     <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // values from before the edge regardless of statement order.
            state     <= state_nx;
            launch    <= launch_nx;
            half_cnt  <= half_nx;
            pulse_cnt <= pulse_nx;
            hold_cnt  <= hold_nx;
            TX_P      <= (state_nx == DRV_P);
            TX_N      <= (state_nx == DRV_N);
            BUSY      <= (state_nx != IDLE);
            RX_EN     <= rx_en_nx;
            DONE      <= done_nx;
        end
    end

endmodule

// File: tb/tb_ultrasonic_transmitter.sv
// -----------------------------------------------------------------------------
// tb_ultrasonic_transmitter
//
// Directed and randomised bursts against ultrasonic_transmitter, with
// HALF_PERIOD=5 and DEAD_CYCLES=1, so one carrier period is 10 cycles.
//
// The stimulus pushes one record per burst that should complete. The monitor
// watches the outputs on every falling edge. On each DONE, it pops a record
// and compares the burst timing against it.
//
// Cycle labels: cyc equals k between rising edge k and edge k+1. An input
// driven at the falling edge of cycle k-1 is sampled at edge k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ultrasonic_transmitter;

    localparam int HP  = 5;
    localparam int DC  = 1;
    localparam int PER = 2 * HP;

    logic        SYS_CLK = 1'b0;
    logic        RST;
    logic        ON;
    logic        FIRE;
    logic [7:0]  NUM_PULSES;
    logic [15:0] HOLDOFF;
    logic        TX_P;
    logic        TX_N;
    logic        BUSY;
    logic        RX_EN;
    logic        DONE;

    ultrasonic_transmitter #(
        .HALF_PERIOD (HP),
        .DEAD_CYCLES (DC)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .ON         (ON),
        .FIRE       (FIRE),
        .NUM_PULSES (NUM_PULSES),
        .HOLDOFF    (HOLDOFF),
        .TX_P       (TX_P),
        .TX_N       (TX_N),
        .BUSY       (BUSY),
        .RX_EN      (RX_EN),
        .DONE       (DONE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int cyc = 0;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    typedef struct {
        int t;   // accepting edge
        int n;   // pulses
        int h;   // hold-off
    } burst_t;

    burst_t exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    logic [4:0] outs;
    assign outs = {TX_P, TX_N, BUSY, RX_EN, DONE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    int     busy_start = 0;
    int     first_n    = -1;
    int     busy_len   = 0;
    int     p_cnt      = 0;
    int     n_cnt      = 0;
    bit     rx_seen    = 1'b0;
    bit     prev_done  = 1'b0;
    burst_t e;

    always @(negedge SYS_CLK) begin
        check("no_overlap", 32'(TX_P & TX_N), 32'd0);
        if (prev_done)
            check("done_one_cycle", 32'(DONE), 32'd0);
        prev_done = DONE;

        if (BUSY) begin
            if (busy_len == 0) busy_start = cyc;
            busy_len++;
            if (TX_P) p_cnt++;
            if (TX_N) begin
                if (first_n < 0) first_n = cyc;
                n_cnt++;
            end
            if (RX_EN) rx_seen = 1'b1;
        end

        if (DONE) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("busy_start",     32'(busy_start), 32'(e.t + 1));
                check("first_tx_n",     32'(first_n),    32'(e.t + 1 + HP));
                check("busy_length",    32'(busy_len),   32'(e.n * PER + e.h));
                check("tx_p_cycles",    32'(p_cnt),      32'(e.n * (HP - DC)));
                check("tx_n_cycles",    32'(n_cnt),      32'(e.n * (HP - DC)));
                check("done_cycle",     32'(cyc),        32'(e.t + 1 + e.n * PER + e.h));
                check("rx_en_at_done",  32'(RX_EN),      32'd1);
                check("rx_low_in_busy", 32'(rx_seen),    32'd0);
            end
        end

        if (!BUSY) begin
            busy_len = 0;
            first_n  = -1;
            p_cnt    = 0;
            n_cnt    = 0;
            rx_seen  = 1'b0;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge SYS_CLK);
    endtask

    // Called at a falling edge; the request is sampled at edge t = cyc+1.
    task automatic fire(input int n, input int h, input bit expect_done, output int t);
        NUM_PULSES = 8'(n);
        HOLDOFF    = 16'(h);
        FIRE       = 1'b1;
        t          = cyc + 1;
        if (expect_done) exp_q.push_back('{t, n, h});
        @(negedge SYS_CLK);
        FIRE = 1'b0;
    endtask

    int t, t2, tz, n, h, stop_at, end_edge;
    bit abort;

    initial begin
        RST        = 1'b1;
        ON         = 1'b0;
        FIRE       = 1'b0;
        NUM_PULSES = '0;
        HOLDOFF    = '0;
        repeat (3) @(negedge SYS_CLK);
        check("reset_outputs", 32'(outs), 32'd0);
        RST = 1'b0;
        ON  = 1'b1;
        repeat (2) @(negedge SYS_CLK);

        // Burst 1 is N=3, H=7. The bench drives junk inputs and re-fires
        // during the burst, and expects them all to be ignored.
        fire(3, 7, 1'b1, t);
        NUM_PULSES = 8'd1;
        HOLDOFF    = 16'd2;
        wait_cyc(t + 1);
        check("first_tx_p",  32'({TX_P, TX_N, BUSY}), 32'b101);
        wait_cyc(t + 5);
        check("dead_p_low",  32'({TX_P, TX_N}), 32'd0);
        wait_cyc(t + 6);
        check("drv_n_high",  32'({TX_P, TX_N}), 32'b01);
        wait_cyc(t + 9);
        FIRE = 1'b1;
        @(negedge SYS_CLK);
        FIRE = 1'b0;
        wait_cyc(t + 34);
        FIRE = 1'b1;
        @(negedge SYS_CLK);
        FIRE = 1'b0;
        wait_cyc(t + 31);
        check("hold_legs_low", 32'({TX_P, TX_N, BUSY}), 32'b001);
        // The request is held across edge t+38 (completion, ignored) and
        // edge t+39 (first IDLE cycle, accepted). It is N=2, H=0.
        wait_cyc(t + 37);
        NUM_PULSES = 8'd2;
        HOLDOFF    = 16'd0;
        FIRE       = 1'b1;
        t2         = t + 39;
        exp_q.push_back('{t2, 2, 0});
        @(negedge SYS_CLK);
        check("completion", 32'({BUSY, RX_EN, DONE}), 32'b011);
        @(negedge SYS_CLK);
        FIRE = 1'b0;
        check("rx_en_cleared", 32'({BUSY, RX_EN}), 32'd0);
        @(negedge SYS_CLK);
        check("second_start", 32'({TX_P, BUSY}), 32'b11);
        wait_cyc(t2 + 1 + 2 * PER + 1);

        // A request with N=0 is ignored, and RX_EN stays high.
        fire(0, 5, 1'b0, tz);
        repeat (3) @(negedge SYS_CLK);
        check("n0_ignored", 32'(outs), 32'b00010);

        // Abort with ON low. The drop is sampled at edge t+13, and the
        // burst must not produce DONE.
        fire(3, 7, 1'b0, t);
        wait_cyc(t + 12);
        check("pre_abort_tx_p", 32'(TX_P), 32'd1);
        ON = 1'b0;
        @(negedge SYS_CLK);
        check("abort_outputs", 32'(outs), 32'd0);
        repeat (3) @(negedge SYS_CLK);
        ON = 1'b1;
        @(negedge SYS_CLK);
        fire(2, 3, 1'b1, t);
        wait_cyc(t + 1 + 2 * PER + 3 + 1);

        // Assert asynchronous reset in the middle of DRV_N, between clock edges.
        fire(2, 4, 1'b0, t);
        wait_cyc(t + 7);
        check("pre_rst_tx_n", 32'(TX_N), 32'd1);
        #2 RST = 1'b1;
        #1 check("async_rst_clear", 32'(outs), 32'd0);
        repeat (3) @(negedge SYS_CLK);
        RST = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        check("post_rst_idle", 32'(outs), 32'd0);
        fire(1, 0, 1'b1, t);
        wait_cyc(t + 1 + PER + 1);

        // Randomised bursts. Each burst picks random N and H and is
        // re-fired at random while busy. About one in five is aborted
        // with ON low. Each new burst is requested in the first IDLE cycle.
        for (int i = 0; i < 40; i++) begin
            n     = $urandom_range(1, 6);
            h     = $urandom_range(0, 15);
            abort = ($urandom_range(0, 4) == 0);
            fire(n, h, !abort, t);
            end_edge = t + 1 + n * PER + h;
            stop_at  = abort ? $urandom_range(t + 1, end_edge - 1) : end_edge;
            while (cyc < stop_at) begin
                FIRE       = ($urandom_range(0, 3) == 0);
                NUM_PULSES = 8'($urandom_range(0, 255));
                HOLDOFF    = 16'($urandom_range(0, 65535));
                @(negedge SYS_CLK);
            end
            FIRE = 1'b0;
            if (abort) begin
                ON = 1'b0;
                @(negedge SYS_CLK);
                check("rand_abort", 32'(outs), 32'd0);
                ON = 1'b1;
                @(negedge SYS_CLK);
            end
        end

        repeat (4) @(negedge SYS_CLK);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge SYS_CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ultrasonic_transmitter.md
Name: ultrasonic_transmitter

Overview:
Generates the ultrasonic excitation burst that pairs with the receive chain. On a fire request it drives a complementary push-pull pulse train with dead time. It then waits a programmable blanking hold-off. After the hold-off it asserts RX_EN, which is wired to the receiver's ON input so that echo capture starts only after transducer ring-down.

Parameters:
HALF_PERIOD, 625, SYS_CLK cycles per half carrier period (50 MHz / 625 / 2 = 40 kHz); legal range 2..65535.
DEAD_CYCLES, 10, both-low dead time at the end of each half period; must satisfy 1 <= DEAD_CYCLES < HALF_PERIOD.

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
ON  in  1  block enable; low aborts any activity synchronously
FIRE  in  1  start request, sampled each cycle
NUM_PULSES  in  8  carrier periods per burst; sampled when FIRE is accepted
HOLDOFF  in  16  blanking cycles after the burst; sampled when FIRE is accepted
TX_P  out  1  positive drive leg
TX_N  out  1  negative drive leg
BUSY  out  1  high from FIRE acceptance until the end of hold-off
RX_EN  out  1  receiver enable level
DONE  out  1  one-cycle pulse when hold-off completes

Behaviour:
- Reset (async): state IDLE; TX_P=TX_N=BUSY=RX_EN=DONE=0; all counters=0. All outputs are registered.
- TX_P and TX_N must never be high in the same cycle, under any input sequence.
- States: IDLE, DRV_P, DEAD_P, DRV_N, DEAD_N, HOLD.
- FIRE acceptance:
  - Accepted at edge t only when state=IDLE, ON=1, FIRE=1 and NUM_PULSES!=0.
  - On acceptance, latch NUM_PULSES and HOLDOFF, and clear RX_EN.
  - From edge t+1: state=DRV_P, TX_P=1, BUSY=1.
- FIRE with NUM_PULSES=0: ignored; no output changes, RX_EN unchanged.
- FIRE while BUSY: ignored; latched values do not change.
- Per carrier period:
  - DRV_P: TX_P=1 for HALF_PERIOD-DEAD_CYCLES cycles.
  - DEAD_P: both outputs low for DEAD_CYCLES cycles.
  - DRV_N: TX_N=1 for HALF_PERIOD-DEAD_CYCLES cycles.
  - DEAD_N: both outputs low for DEAD_CYCLES cycles.
  - One period is exactly 2*HALF_PERIOD cycles.
- Pulse counter decrements at the end of each DEAD_N. If the count was 1, go to HOLD; otherwise go to DRV_P. Burst length is exactly NUM_PULSES*2*HALF_PERIOD cycles.
- HOLD:
  - Lasts exactly the latched HOLDOFF cycles with TX_P=TX_N=0 and BUSY=1.
  - HOLDOFF=0 skips HOLD: the cycle after the last DEAD_N is the completion cycle.
- Completion (one edge):
  - State goes to IDLE, BUSY=0, RX_EN=1, DONE=1 for exactly one cycle.
  - RX_EN then stays 1 until the next accepted FIRE, until ON=0, or until RST.
- ON=0 in any state: at the next edge, state=IDLE, TX_P=TX_N=BUSY=RX_EN=DONE=0, counters cleared. No DONE is produced for an aborted burst.
- RST mid-burst: outputs clear immediately (asynchronous), with no glitch where both legs are high.
- FIRE in the same cycle as completion: not accepted, since state is not yet IDLE. FIRE in the first IDLE cycle is accepted.
- Counter widths: half-period counter 16 bits, pulse counter 8 bits, hold-off counter 16 bits. Counters load terminal values and count down to 1; no wrap-around is reachable.

Test Plan:
1. Setup: HALF_PERIOD=5, DEAD_CYCLES=1, ON=1, NUM_PULSES=3, HOLDOFF=7, FIRE pulsed at t. Required response:
   - TX_P high t+1..t+4, both low t+5, TX_N high t+6..t+9, both low t+10; pattern repeats 3 times (30 cycles).
   - HOLD covers t+31..t+37.
   - DONE=1 and RX_EN rises at t+38; BUSY=1 exactly over t+1..t+37.
2. Same setup with HOLDOFF=0: DONE and RX_EN rise at t+31. With NUM_PULSES=0: no activity and RX_EN unchanged.
3. FIRE re-pulsed at t+10 and t+35 during burst 1: ignored, identical waveform. A second FIRE at t+39 clears RX_EN at t+39 and starts a new burst at t+40.
4. ON dropped at t+12: all outputs 0 at t+13, no DONE. ON restored and FIRE applied: a clean full burst follows.
5. RST asserted asynchronously mid-DRV_N: TX_N falls without waiting for a clock edge, and all outputs stay 0 until FIRE follows RST release.
6. Random FIRE/ON/NUM_PULSES/HOLDOFF over 10^5 cycles: assertion that TX_P&TX_N never holds, and that every burst length equals NUM_PULSES*10.
